ps2_host_transmitter: RTL and testbench
=======================================

# ps2_host_transmitter

Host-to-device side of the PS/2 link: accepts one command byte per handshake and transmits it to the mouse using the PS/2 host-request protocol. It covers inhibit, start, 8 data bits, odd parity, stop and device ACK. It shares the open-drain `ps2_clk`/`ps2_data` pins with the mouse receive path and sits beside that receiver in the top level. Its first use is sending 0xFF (reset) and 0xF4 (enable data reporting) after power-up.

## Interface
Parameters:
- `INHIBIT_CYCLES`, 12_000: cycles the clock line is held low before start (120 µs @ 100 MHz).
- `START_TIMEOUT_CYCLES`, 1_500_000: maximum wait for the first device falling edge after the clock is released (15 ms).
- `PACKET_TIMEOUT_CYCLES`, 200_000: maximum time from first falling edge to ACK (2 ms).

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst`  in  1  asynchronous, active-low reset (0 = reset).
- `tx_valid`  in  1  command byte offered.
- `tx_ready`  out  1  high only in IDLE; transfer occurs on `tx_valid && tx_ready`.
- `tx_data`  in  8  command byte, latched on transfer.
- `ps2_clk_in`, `ps2_data_in`  in  1 each  raw pin levels (asynchronous).
- `ps2_clk_oe`, `ps2_data_oe`  out  1 each  1 = pull line low; 0 = release (pulled up).
- `busy`  out  1  high from transfer until return to IDLE; the receiver ignores frames while high.
- `done`  out  1  one-cycle pulse when the frame completes.
- `ack_ok`  out  1  valid with `done`; 1 if the device ACK bit sampled 0.
- `error`  out  1  one-cycle pulse on timeout; `done` is not asserted.

## Operation
- Inputs pass through a 2-FF synchronizer. A falling edge is synchronized value 1→0 between consecutive cycles.
- Reset values: `tx_ready`=1. `busy`, `done`, `ack_ok`, `error`, `ps2_clk_oe` and `ps2_data_oe` are all 0. Both lines are released asynchronously the moment `rst`=0.
- Parity bit is `~^tx_data` (odd parity over data plus parity bit).
- States:
  - IDLE: `tx_ready`=1. On transfer, latch data and parity, then go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for exactly `INHIBIT_CYCLES` cycles. On the last cycle set `ps2_data_oe`=1 (start bit), then go to RELEASE.
  - RELEASE: `ps2_clk_oe`=0, `ps2_data_oe` stays 1. Wait for a falling edge; on timeout go to ABORT. On the edge, go to SHIFT with edge count = 1.
  - SHIFT: at each falling edge with count k:
    - k = 1..8: drive data bit k-1 (LSB first; `ps2_data_oe` = ~bit).
    - k = 9: drive parity.
    - k = 10: release data (stop bit).
    - k = 11: sample `ps2_data_in`; set `ack_ok` = (sample == 0); go to WAIT_IDLE.
    - If the packet timeout expires first, go to ABORT.
  - WAIT_IDLE: wait until both synchronized lines are high (packet timer still running), then pulse `done` and go to IDLE.
  - ABORT: release both lines, pulse `error`, go to IDLE. A pending partial frame is discarded.
- Edge count is 4 bits; the packet timer starts at the first falling edge. Timer widths are `$clog2` of the largest timeout.
- `tx_valid` while not IDLE is ignored (no queueing).
- `ack_ok` holds its value until the next `done`.

## Timing
- Line update follows the pin falling edge by ≤3 cycles (2 synchronizer + 1 register). This is far inside the ≥30 µs clock-low half-period.
- INHIBIT `ps2_clk_oe` high width is exactly `INHIBIT_CYCLES` cycles. Start-bit data-low overlaps clock-low by 1 cycle.
- `tx_ready` drops the cycle after transfer and returns the cycle after the `done`/`error` pulse.
- `done` and `error` are mutually exclusive and never asserted together.

## Structure
- Shared package/include `ps2_defs` holds:
  - state encodings;
  - `PS2_FRAME_EDGES` = 11;
  - command constants `PS2_CMD_RESET` 8'hFF, `PS2_CMD_ENABLE` 8'hF4, `PS2_CMD_SET_RATE` 8'hF3;
  - ACK byte 8'hFA (used by the receiver).
- Sub-module `ps2_line_sync`: 2-FF synchronizer plus falling-edge detector for one line. Instantiated twice here and reused by the mouse receiver.

## Test plan
Bench uses `INHIBIT_CYCLES`=100, `START_TIMEOUT_CYCLES`=2000, `PACKET_TIMEOUT_CYCLES`=5000, with a device model clocking at a 40-cycle period.
- Send 0xF4, device ACKs → data sampled at device rising edges is 0,0,0,1,0,1,1,1,1,0(parity),1(stop); `done`=1 for 1 cycle, `ack_ok`=1, `ps2_clk_oe` high exactly 100 cycles.
- Send 0x00 → parity bit 1; `done` with `ack_ok`=1.
- Device leaves data high at ACK → `done` pulse with `ack_ok`=0, no `error`.
- Device never clocks after release → `error` pulse 2000 cycles after RELEASE entry; both `oe`=0; `tx_ready`=1 next cycle; `done` stays 0.
- Assert `rst`=0 during bit 4 → both `oe`=0 in the same cycle; after release: `tx_ready`=1, `busy`=0.
- Hold `tx_valid` with 0xFF, then 0xF4 during the first frame → second byte accepted only the cycle after `done`; two complete frames observed in order.

Source files
------------

// File: rtl/ps2_defs.sv
// Shared PS/2 definitions: transmitter state encoding, frame length, command and ACK bytes.
// Imported by the host transmitter and the mouse receiver.
package ps2_defs;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RELEASE,
    ST_SHIFT,
    ST_WAIT_IDLE,
    ST_ABORT
  } ps2_tx_state_e;

  localparam logic [3:0] PS2_FRAME_EDGES = 4'd11;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] PS2_ACK          = 8'hFA;

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge detector on the synchronized value.
// Lines idle high, so every stage resets to 1 and no false edge appears after reset.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_sync,
  output logic line_fall
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  always_comb begin
    meta_d = line_in;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign line_sync = sync_q;
  assign line_fall = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data bits LSB first,
// odd parity, stop, and device ACK sampling, with start and packet timeouts.
module ps2_host_transmitter
  import ps2_defs::*;
#(
  parameter int INHIBIT_CYCLES        = 12_000,
  parameter int START_TIMEOUT_CYCLES  = 1_500_000,
  parameter int PACKET_TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic [7:0] tx_data,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int MAX_A     = (INHIBIT_CYCLES > START_TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : START_TIMEOUT_CYCLES;
  localparam int TIMER_MAX = (MAX_A > PACKET_TIMEOUT_CYCLES) ? MAX_A : PACKET_TIMEOUT_CYCLES;
  localparam int TW        = $clog2(TIMER_MAX);

  localparam logic [TW-1:0] START_BIT_AT = TW'(INHIBIT_CYCLES - 2);
  localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] START_LAST   = TW'(START_TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] PACKET_LAST  = TW'(PACKET_TIMEOUT_CYCLES - 1);

  logic clk_sync, clk_fall;
  logic data_sync, data_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2_clk_in),
    .line_sync (clk_sync),
    .line_fall (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk       (clk),
    .rst       (rst),
    .line_in   (ps2_data_in),
    .line_sync (data_sync),
    .line_fall (data_fall_unused)
  );

  ps2_tx_state_e state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    edge_cnt_q, edge_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          ack_ok_q, ack_ok_d;
  logic          ack_sample_q, ack_sample_d;

  // The done cycle is already IDLE, so ready is masked for it to keep the next transfer one cycle later.
  assign tx_ready = (state_q == ST_IDLE) && !done_q;

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    edge_cnt_d   = edge_cnt_q;
    shift_d      = shift_q;
    clk_oe_d     = clk_oe_q;
    data_oe_d    = data_oe_q;
    done_d       = 1'b0;
    error_d      = 1'b0;
    ack_ok_d     = ack_ok_q;
    ack_sample_d = ack_sample_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready) begin
          shift_d  = {~^tx_data, tx_data};
          timer_d  = '0;
          clk_oe_d = 1'b1;
          state_d  = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == START_BIT_AT) data_oe_d = 1'b1;
        if (timer_q == INHIBIT_LAST) begin
          clk_oe_d = 1'b0;
          timer_d  = '0;
          state_d  = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        timer_d = timer_q + 1'b1;
        if (clk_fall) begin
          data_oe_d  = ~shift_q[0];
          shift_d    = {1'b1, shift_q[8:1]};
          edge_cnt_d = 4'd1;
          timer_d    = '0;
          state_d    = ST_SHIFT;
        end else if (timer_q == START_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_ABORT;
        end
      end

      // Shift register refills with ones, so edge 10 releases data as the stop bit.
      ST_SHIFT: begin
        timer_d = timer_q + 1'b1;
        if (timer_q == PACKET_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_ABORT;
        end else if (clk_fall) begin
          edge_cnt_d = edge_cnt_q + 4'd1;
          if (edge_cnt_q + 4'd1 == PS2_FRAME_EDGES) begin
            ack_sample_d = ~data_sync;
            state_d      = ST_WAIT_IDLE;
          end else begin
            data_oe_d = ~shift_q[0];
            shift_d   = {1'b1, shift_q[8:1]};
          end
        end
      end

      ST_WAIT_IDLE: begin
        timer_d = timer_q + 1'b1;
        if (clk_sync && data_sync) begin
          done_d   = 1'b1;
          ack_ok_d = ack_sample_q;
          state_d  = ST_IDLE;
        end else if (timer_q == PACKET_LAST) begin
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          error_d   = 1'b1;
          state_d   = ST_ABORT;
        end
      end

      ST_ABORT: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end

      default: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      shift_q      <= '0;
      clk_oe_q     <= 1'b0;
      data_oe_q    <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      ack_ok_q     <= 1'b0;
      ack_sample_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      shift_q      <= shift_d;
      clk_oe_q     <= clk_oe_d;
      data_oe_q    <= data_oe_d;
      done_q       <= done_d;
      error_q      <= error_d;
      ack_ok_q     <= ack_ok_d;
      ack_sample_q <= ack_sample_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign error       = error_q;
  assign ack_ok      = ack_ok_q;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// Self-checking bench for ps2_host_transmitter: a PS/2 device model on open-drain lines,
// a transaction-level reference model, and a per-cycle compare process.
module tb_ps2_host_transmitter;

  localparam int INH  = 100;
  localparam int STO  = 2000;
  localparam int PTO  = 5000;
  localparam int HALF = 20;

  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, done, ack_ok, error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       devClk = 1'b1;
  logic       devData = 1'b1;
  logic       clkLine, dataLine;

  assign clkLine  = ~ps2_clk_oe & devClk;
  assign dataLine = ~ps2_data_oe & devData;

  always #5 clock = ~clock;

  ps2_host_transmitter #(
    .INHIBIT_CYCLES        (INH),
    .START_TIMEOUT_CYCLES  (STO),
    .PACKET_TIMEOUT_CYCLES (PTO)
  ) dut (
    .clk         (clock),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .ps2_clk_in  (clkLine),
    .ps2_data_in (dataLine),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .ack_ok      (ack_ok),
    .error       (error)
  );

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;

  // Device behaviour: 0 = ACK, 1 = no ACK, 2 = never clocks.
  int  devMode = 0;
  int  devEdges = 11;
  int  devEdgeCount = 0;
  bit  devBusy = 1'b0;
  logic [10:0] lastCap = '0;
  logic [10:0] capQ[$];

  bit  modelReady = 1'b1;
  bit  modelAck = 1'b0;
  bit  curAck = 1'b1;
  bit  expectError = 1'b0;
  logic [8:0] expQ[$];

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycleCount);
    end
  endtask

  // Frame as the device sees it: start 0, data LSB first, parity making the one-count odd, stop 1.
  function automatic logic [10:0] frameBits(input logic [7:0] b);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
    f[9]  = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Per-cycle compare against the transaction-level model.
  always @(negedge clock) begin
    if (!rst) begin
      modelReady = 1'b1;
      modelAck   = 1'b0;
      expQ.delete();
      capQ.delete();
    end else begin
      logic [8:0] e;
      if (done) begin
        checkOutput("done_expected", expQ.size() != 0, 1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          modelAck = e[8];
          checkOutput("frame_captured", capQ.size() != 0, 1);
          if (capQ.size() != 0) checkOutput("frame_bits", capQ.pop_front(), frameBits(e[7:0]));
        end
        checkOutput("done_error_excl", error, 0);
      end
      if (error) begin
        checkOutput("error_expected", error, expectError);
        checkOutput("error_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
        if (expQ.size() != 0) void'(expQ.pop_front());
      end
      checkOutput("tx_ready", tx_ready, modelReady);
      checkOutput("busy", busy, !modelReady && !done);
      checkOutput("ack_ok_hold", ack_ok, modelAck);
      if (done || error) modelReady = 1'b1;
      else if (modelReady && tx_valid) begin
        modelReady = 1'b0;
        expQ.push_back({curAck, tx_data});
      end
    end
  end

  // Inhibit width and start-bit overlap monitor.
  int   inhRun = 0;
  logic d1 = 1'b0, d2 = 1'b0;
  always @(negedge clock) begin
    if (!rst) begin
      inhRun = 0;
    end else if (ps2_clk_oe) begin
      inhRun++;
      d2 = d1;
      d1 = ps2_data_oe;
    end else if (inhRun > 0) begin
      checkOutput("inhibit_width", inhRun, INH);
      checkOutput("start_overlap", {d2, d1}, 2'b01);
      inhRun = 0;
    end
  end

  // PS/2 device model: answers a request-to-send by clocking at a 2*HALF period.
  initial begin
    logic [10:0] cap;
    forever begin
      @(negedge clock);
      if (rst && !ps2_clk_oe && ps2_data_oe) begin
        devBusy = 1'b1;
        if (devMode == 2) begin
          while (ps2_data_oe) @(negedge clock);
        end else begin
          repeat ($urandom_range(5, 60)) @(posedge clock);
          #1;
          cap = '0;
          cap[0] = dataLine;
          for (int k = 1; k <= devEdges; k++) begin
            devEdgeCount = k;
            devClk = 1'b0;
            repeat (HALF) @(posedge clock);
            #1;
            devClk = 1'b1;
            if (k == 11) begin
              capQ.push_back(cap);
              lastCap = cap;
              repeat (5) @(posedge clock);
              #1;
              devData = 1'b1;
            end else begin
              cap[k] = dataLine;
              if (k == 10 && devMode == 0) begin
                repeat (5) @(posedge clock);
                #1;
                devData = 1'b0;
                repeat (HALF - 5) @(posedge clock);
                #1;
              end else begin
                repeat (HALF) @(posedge clock);
                #1;
              end
            end
          end
        end
        devBusy = 1'b0;
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int mode);
    devMode = mode;
    curAck  = (mode == 0);
    for (int n = 0; n < 5000; n++) begin
      @(posedge clock);
      #1;
      if (tx_ready) break;
    end
    checkOutput("ready_before_send", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic waitEnd(output bit gotDone, output bit gotErr);
    for (int n = 0; n < 4000; n++) begin
      @(negedge clock);
      if (done || error) break;
    end
    gotDone = done;
    gotErr  = error;
    checkOutput("frame_end_seen", done | error, 1);
    @(negedge clock);
    checkOutput("pulse_one_cycle", done | error, 0);
  endtask

  initial begin
    bit gd, ge;
    int r, e, dCycle;
    logic [7:0] b;

    repeat (3) @(negedge clock);
    checkOutput("reset_tx_ready", tx_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ack_ok", ack_ok, 0);
    checkOutput("reset_error", error, 0);
    checkOutput("reset_clk_oe", ps2_clk_oe, 0);
    checkOutput("reset_data_oe", ps2_data_oe, 0);
    @(posedge clock);
    #1 rst = 1'b1;
    repeat (5) @(posedge clock);

    $display("[TB] frame 0xF4 with ACK");
    applyStimulus(8'hF4, 0);
    waitEnd(gd, ge);
    checkOutput("f4_done", gd, 1);
    checkOutput("f4_frame_literal", lastCap, 11'h5E8);
    checkOutput("f4_ack_literal", ack_ok, 1);

    $display("[TB] frame 0x00 with ACK");
    applyStimulus(8'h00, 0);
    waitEnd(gd, ge);
    checkOutput("zero_done", gd, 1);
    checkOutput("zero_frame_literal", lastCap, 11'h600);
    checkOutput("zero_ack_literal", ack_ok, 1);

    $display("[TB] frame without device ACK");
    applyStimulus(8'h5A, 1);
    waitEnd(gd, ge);
    checkOutput("noack_done", gd, 1);
    checkOutput("noack_no_error", ge, 0);
    checkOutput("noack_ack_literal", ack_ok, 0);

    $display("[TB] start timeout");
    expectError = 1'b1;
    applyStimulus(8'h3C, 2);
    for (int n = 0; n < 500; n++) begin
      @(negedge clock);
      if (!ps2_clk_oe) break;
    end
    r = cycleCount;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clock);
      if (error || done) break;
    end
    e = cycleCount;
    checkOutput("timeout_error_seen", error, 1);
    checkOutput("timeout_no_done", done, 0);
    checkOutput("timeout_delay", e - r, STO);
    @(negedge clock);
    checkOutput("timeout_ready_next", tx_ready, 1);
    checkOutput("timeout_done_low", done, 0);
    expectError = 1'b0;

    $display("[TB] reset during bit 4");
    b = 8'hA5;
    devEdgeCount = 0;
    devEdges = 5;
    applyStimulus(b, 0);
    for (int n = 0; n < 2000; n++) begin
      @(posedge clock);
      if (devEdgeCount == 5) break;
    end
    checkOutput("reached_bit4", devEdgeCount, 5);
    repeat (8) @(posedge clock);
    #3;
    checkOutput("bit4_driven", ps2_data_oe, !b[4]);
    rst = 1'b0;
    #1;
    checkOutput("reset_async_clk_oe", ps2_clk_oe, 0);
    checkOutput("reset_async_data_oe", ps2_data_oe, 0);
    repeat (3) @(posedge clock);
    #1 rst = 1'b1;
    @(negedge clock);
    checkOutput("after_reset_ready", tx_ready, 1);
    checkOutput("after_reset_busy", busy, 0);
    for (int n = 0; n < 1000; n++) begin
      @(posedge clock);
      if (!devBusy) break;
    end
    checkOutput("device_idle", devBusy, 0);
    devEdges = 11;

    $display("[TB] held tx_valid, back-to-back frames");
    devMode = 0;
    curAck  = 1'b1;
    applyStimulus(8'hFF, 0);
    tx_valid = 1'b1;
    tx_data  = 8'hF4;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clock);
      if (done || error) break;
    end
    checkOutput("first_done", done, 1);
    dCycle = cycleCount;
    checkOutput("ready_low_in_done", tx_ready, 0);
    for (int n = 0; n < 10; n++) begin
      @(negedge clock);
      if (tx_ready) break;
    end
    checkOutput("second_accept_delay", cycleCount - dCycle, 1);
    @(posedge clock);
    #1 tx_valid = 1'b0;
    waitEnd(gd, ge);
    checkOutput("second_done", gd, 1);

    $display("[TB] randomized frames");
    for (int i = 0; i < 6; i++) begin
      int m;
      b = 8'($urandom);
      m = $urandom_range(0, 1);
      applyStimulus(b, m);
      waitEnd(gd, ge);
      checkOutput("rand_done", gd, 1);
      checkOutput("rand_ack", ack_ok, (m == 0) ? 1 : 0);
    end

    repeat (20) @(negedge clock);
    checkOutput("queues_drained", expQ.size() + capQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
